// File: rtl/alarm_controller.sv
// Alarm controller: compares the running BCD clock against an HH:MM setpoint,
// rings a pulsed buzzer on a match and handles snooze/dismiss.
module alarm_controller #(
    parameter int CLK_HZ         = 50000000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] clock_display,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        snooze_btn,
    input  logic        dismiss_btn,
    output logic        buzzer,
    output logic        alarm_active,
    output logic        snoozing,
    output logic [15:0] snooze_time
);

    localparam int HALF_PERIOD = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int BEEP_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(HALF_PERIOD - 1);
    localparam logic [7:0]        RING_LAST = 8'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } state_t;

    state_t            state;
    logic [23:0]       prev_display;
    logic [BEEP_W-1:0] beep_cnt;
    logic [7:0]        ring_cnt;

    logic        tick;
    logic        new_minute;
    logic [15:0] target;
    logic        match;
    logic [15:0] snooze_next;

    // BCD HH:MM plus SNOOZE_MINUTES; minutes never exceed 118 so one wrap suffices.
    function automatic logic [15:0] add_snooze(input logic [15:0] hhmm);
        logic [6:0] hours;
        logic [7:0] minutes;
        hours   = 7'(hhmm[15:12]) * 7'd10 + 7'(hhmm[11:8]);
        minutes = 8'(hhmm[7:4]) * 8'd10 + 8'(hhmm[3:0]) + 8'(SNOOZE_MINUTES);
        if (minutes >= 8'd60) begin
            minutes = minutes - 8'd60;
            hours   = (hours == 7'd23) ? 7'd0 : hours + 7'd1;
        end
        return {4'(hours / 7'd10), 4'(hours % 7'd10),
                4'(minutes / 8'd10), 4'(minutes % 8'd10)};
    endfunction

    assign tick        = (clock_display != prev_display);
    assign new_minute  = tick && (clock_display[7:0] == 8'h00);
    assign target      = (state == SNOOZE) ? snooze_time : alarm_time;
    assign match       = new_minute && (clock_display[23:8] == target);
    assign snooze_next = add_snooze(clock_display[23:8]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_display <= 24'h000000;
            beep_cnt     <= '0;
            ring_cnt     <= 8'd0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
            snooze_time  <= 16'h0000;
        end else begin
            prev_display <= clock_display;
            if (!alarm_enable) begin
                state        <= IDLE;
                beep_cnt     <= '0;
                ring_cnt     <= 8'd0;
                buzzer       <= 1'b0;
                alarm_active <= 1'b0;
                snoozing     <= 1'b0;
                snooze_time  <= 16'h0000;
            end else begin
                case (state)
                    IDLE: begin
                        if (match) begin
                            state        <= RINGING;
                            beep_cnt     <= '0;
                            ring_cnt     <= 8'd0;
                            buzzer       <= 1'b1;
                            alarm_active <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (dismiss_btn) begin
                            state        <= IDLE;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else if (snooze_btn) begin
                            state        <= SNOOZE;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                            snoozing     <= 1'b1;
                            snooze_time  <= snooze_next;
                        end else if (tick && ring_cnt == RING_LAST) begin
                            state        <= IDLE;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else begin
                            if (tick) begin
                                ring_cnt <= ring_cnt + 8'd1;
                            end
                            // Half-period beep: toggle the buzzer each time the counter wraps.
                            if (beep_cnt == BEEP_LAST) begin
                                beep_cnt <= '0;
                                buzzer   <= ~buzzer;
                            end else begin
                                beep_cnt <= beep_cnt + 1'b1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (dismiss_btn) begin
                            state       <= IDLE;
                            snoozing    <= 1'b0;
                            snooze_time <= 16'h0000;
                        end else if (match) begin
                            state        <= RINGING;
                            beep_cnt     <= '0;
                            ring_cnt     <= 8'd0;
                            buzzer       <= 1'b1;
                            alarm_active <= 1'b1;
                            snoozing     <= 1'b0;
                            snooze_time  <= 16'h0000;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                        snoozing     <= 1'b0;
                        snooze_time  <= 16'h0000;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random stimulus,
// checked every cycle against a time-of-day based behavioural model.
module tb_alarm_controller;

    localparam int SNOOZE_MIN = 5;
    localparam int RING_TICKS = 3;
    localparam int HALF_BEEP  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] clock_display = 24'h000000;
    logic [15:0] alarm_time = 16'h0730;
    logic        alarm_enable = 1'b1;
    logic        snooze_btn = 1'b0;
    logic        dismiss_btn = 1'b0;
    logic        buzzer;
    logic        alarm_active;
    logic        snoozing;
    logic [15:0] snooze_time;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    // Model: mode 0 = quiet, 1 = ringing, 2 = snoozed.
    int          m_mode = 0;
    int          m_ticks = 0;
    int          m_cycles = 0;
    logic [23:0] m_prev = 24'h0;
    logic [15:0] m_snooze = 16'h0;
    logic        exp_buzzer = 1'b0;
    logic        exp_active = 1'b0;
    logic        exp_snoozing = 1'b0;
    logic [15:0] exp_snooze_time = 16'h0;

    int          sod;
    int          r;
    logic [23:0] d;
    logic [15:0] base;
    logic        snz;
    logic        dis;
    logic        en;

    alarm_controller #(
        .CLK_HZ(10),
        .RING_SECONDS(RING_TICKS),
        .SNOOZE_MINUTES(SNOOZE_MIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clock_display(clock_display),
        .alarm_time(alarm_time),
        .alarm_enable(alarm_enable),
        .snooze_btn(snooze_btn),
        .dismiss_btn(dismiss_btn),
        .buzzer(buzzer),
        .alarm_active(alarm_active),
        .snoozing(snoozing),
        .snooze_time(snooze_time)
    );

    always #5 clk = ~clk;

    function automatic int bcd2(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] tobcd2(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic int sod_of(input logic [23:0] x);
        return bcd2(x[23:16]) * 3600 + bcd2(x[15:8]) * 60 + bcd2(x[7:0]);
    endfunction

    function automatic logic [23:0] disp_of(input int s);
        return {tobcd2(s / 3600), tobcd2((s / 60) % 60), tobcd2(s % 60)};
    endfunction

    // Snooze target as minutes-of-day arithmetic, wrapping at midnight.
    function automatic logic [15:0] plus_snooze(input logic [15:0] hm);
        int t;
        t = (bcd2(hm[15:8]) * 60 + bcd2(hm[7:0]) + SNOOZE_MIN) % 1440;
        return {tobcd2(t / 60), tobcd2(t % 60)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] disp, input logic s, input logic dm, input logic e);
        @(posedge clk);
        #1;
        clock_display = disp;
        snooze_btn    = s;
        dismiss_btn   = dm;
        alarm_enable  = e;
    endtask

    task automatic settle();
        applyStimulus(clock_display, 1'b0, 1'b0, alarm_enable);
    endtask

    task automatic enter_ring_model();
        m_mode   = 1;
        m_ticks  = 0;
        m_cycles = 0;
    endtask

    // Reference model advances on every rising edge using the inputs held since the previous edge.
    task automatic model_step();
        logic tick;
        logic new_minute;
        if (!rst_n) begin
            m_mode   = 0;
            m_prev   = 24'h0;
            m_snooze = 16'h0;
            m_ticks  = 0;
            m_cycles = 0;
        end else begin
            tick       = (clock_display != m_prev);
            new_minute = tick && (clock_display[7:0] == 8'h00);
            if (!alarm_enable) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (new_minute && clock_display[23:8] == alarm_time) enter_ring_model();
            end else if (m_mode == 1) begin
                if (dismiss_btn) begin
                    m_mode = 0;
                end else if (snooze_btn) begin
                    m_mode   = 2;
                    m_snooze = plus_snooze(clock_display[23:8]);
                end else begin
                    if (tick) m_ticks++;
                    if (m_ticks == RING_TICKS) m_mode = 0;
                    else m_cycles++;
                end
            end else begin
                if (dismiss_btn) m_mode = 0;
                else if (new_minute && clock_display[23:8] == m_snooze) enter_ring_model();
            end
            m_prev = clock_display;
        end
        exp_active      = (m_mode == 1);
        exp_snoozing    = (m_mode == 2);
        exp_snooze_time = (m_mode == 2) ? m_snooze : 16'h0000;
        exp_buzzer      = (m_mode == 1) && (((m_cycles / HALF_BEEP) % 2) == 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every falling edge once reset has been applied.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("buzzer", {15'b0, buzzer}, {15'b0, exp_buzzer});
                checkOutput("alarm_active", {15'b0, alarm_active}, {15'b0, exp_active});
                checkOutput("snoozing", {15'b0, snoozing}, {15'b0, exp_snoozing});
                checkOutput("snooze_time", snooze_time, exp_snooze_time);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        checkOutput("reset buzzer", {15'b0, buzzer}, 16'h0000);
        checkOutput("reset alarm_active", {15'b0, alarm_active}, 16'h0000);
        checkOutput("reset snoozing", {15'b0, snoozing}, 16'h0000);
        checkOutput("reset snooze_time", snooze_time, 16'h0000);
        rst_n = 1'b1;

        // Basic ring and beep cadence
        applyStimulus(24'h072959, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h073000, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("ring active", {15'b0, alarm_active}, 16'h0001);
        checkOutput("ring buzzer first", {15'b0, buzzer}, 16'h0001);
        repeat (4) settle();
        checkOutput("buzzer still high", {15'b0, buzzer}, 16'h0001);
        settle();
        checkOutput("buzzer low after 5", {15'b0, buzzer}, 16'h0000);
        checkOutput("model buzzer low", {15'b0, exp_buzzer}, 16'h0000);
        repeat (5) settle();
        checkOutput("buzzer high after 10", {15'b0, buzzer}, 16'h0001);

        // Snooze and re-ring
        applyStimulus(24'h073000, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("snoozing", {15'b0, snoozing}, 16'h0001);
        checkOutput("snooze_time 0735", snooze_time, 16'h0735);
        checkOutput("model snooze 0735", exp_snooze_time, 16'h0735);
        checkOutput("snooze buzzer off", {15'b0, buzzer}, 16'h0000);
        applyStimulus(24'h073459, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h073500, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("re-ring", {15'b0, alarm_active}, 16'h0001);

        // Auto-stop after three ticks
        applyStimulus(24'h073501, 1'b0, 1'b0, 1'b1);
        applyStimulus(24'h073502, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("ringing before 3rd tick", {15'b0, alarm_active}, 16'h0001);
        applyStimulus(24'h073503, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("auto-stop", {15'b0, alarm_active}, 16'h0000);
        checkOutput("auto-stop buzzer", {15'b0, buzzer}, 16'h0000);

        // Midnight wrap
        alarm_time = 16'h2358;
        applyStimulus(24'h235759, 1'b0, 1'b0, 1'b1);
        applyStimulus(24'h235800, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h235800, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("snooze_time 0003", snooze_time, 16'h0003);
        checkOutput("model snooze 0003", exp_snooze_time, 16'h0003);
        applyStimulus(24'h235800, 1'b0, 1'b1, 1'b1);
        settle();
        checkOutput("dismiss snooze", snooze_time, 16'h0000);

        // Hour digit carry 09 -> 10
        alarm_time = 16'h0957;
        applyStimulus(24'h095700, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h095700, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("snooze_time 1002", snooze_time, 16'h1002);
        applyStimulus(24'h095700, 1'b0, 1'b1, 1'b1);

        // Simultaneous snooze and dismiss
        alarm_time = 16'h1200;
        applyStimulus(24'h120000, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("ring at 1200", {15'b0, alarm_active}, 16'h0001);
        applyStimulus(24'h120000, 1'b1, 1'b1, 1'b1);
        settle();
        checkOutput("dismiss wins active", {15'b0, alarm_active}, 16'h0000);
        checkOutput("dismiss wins snoozing", {15'b0, snoozing}, 16'h0000);

        // Disable mid-ring
        alarm_time = 16'h1300;
        applyStimulus(24'h130000, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h130000, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("disable stops ring", {15'b0, alarm_active}, 16'h0000);
        checkOutput("disable buzzer", {15'b0, buzzer}, 16'h0000);
        applyStimulus(24'h130000, 1'b0, 1'b0, 1'b1);

        // Reset while snoozing
        alarm_time = 16'h1400;
        applyStimulus(24'h140000, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h140000, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("snooze 1405", snooze_time, 16'h1405);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clock_display = 24'h140001;
        settle();
        checkOutput("rst snoozing", {15'b0, snoozing}, 16'h0000);
        checkOutput("rst snooze_time", snooze_time, 16'h0000);
        checkOutput("rst buzzer", {15'b0, buzzer}, 16'h0000);
        rst_n = 1'b1;

        // Disabled at match
        alarm_time = 16'h1500;
        applyStimulus(24'h145959, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'h150000, 1'b0, 1'b0, 1'b0);
        settle();
        applyStimulus(24'h150000, 1'b0, 1'b0, 1'b1);
        settle();
        settle();
        checkOutput("disabled match no ring", {15'b0, alarm_active}, 16'h0000);

        // No false fire, then clock set straight onto the alarm
        alarm_time = 16'h0730;
        applyStimulus(24'h072959, 1'b0, 1'b0, 1'b1);
        applyStimulus(24'h073000, 1'b0, 1'b0, 1'b1);
        settle();
        applyStimulus(24'h073000, 1'b0, 1'b1, 1'b1);
        repeat (100) settle();
        checkOutput("held display no re-ring", {15'b0, alarm_active}, 16'h0000);
        applyStimulus(24'h073001, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("073001 no ring", {15'b0, alarm_active}, 16'h0000);
        applyStimulus(24'h073000, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("clock set rings", {15'b0, alarm_active}, 16'h0001);
        applyStimulus(24'h073000, 1'b0, 1'b1, 1'b1);

        // Randomised phase around the alarm and snooze targets
        sod = sod_of(clock_display);
        for (int i = 0; i < 3000; i++) begin
            d = clock_display;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                base = (m_mode == 2) ? m_snooze : alarm_time;
                sod  = (sod_of({base, 8'h00}) + 86400 - int'($urandom_range(1, 4))) % 86400;
                d    = disp_of(sod);
            end else if (r < 40) begin
                sod = (sod + 1) % 86400;
                d   = disp_of(sod);
            end
            if ($urandom_range(0, 199) == 0) begin
                d    = disp_of((sod + 60 * int'($urandom_range(0, 3))) % 86400);
                base = d[23:8];
                alarm_time = base;
                d    = clock_display;
            end
            en  = ($urandom_range(0, 99) != 0);
            snz = ($urandom_range(0, 9) == 0);
            dis = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            if (!rst_n) sod = sod_of(d);
            applyStimulus(d, snz, dis, en);
        end
        rst_n = 1'b1;
        repeat (3) settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
